// File: rtl/mem_pkg.sv
// Shared constants and the controller state type for the memory access controller.
package mem_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 6;
  localparam int RD_LATENCY         = 2;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

endpackage

// File: rtl/mem_access_ctrl_resp_fifo.sv
// Read-response buffer: circular FIFO with wrapping pointers and an occupancy count.
module resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = storage[rd_ptr];

  // Payload storage is deliberately left out of reset; only pointers and count gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      storage[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: clears the bank after reset, then serves host reads/writes
// with credit-based flow control into an in-order read-response buffer.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  mem_write_en,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  init_done
);

  localparam int CW = $clog2(RESP_DEPTH) + 1;
  localparam int SW = CW + 1;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] clear_cnt;
  logic [RD_LATENCY-1:0] rd_pipe;
  logic [CW-1:0]         occupancy;
  logic [SW-1:0]         inflight_cnt;
  logic                  rd_credit;
  logic                  fifo_empty;
  logic                  resp_pop;

  // A read may only issue if every read already committed still has a buffer slot reserved.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight_cnt = inflight_cnt + SW'(rd_pipe[i]);
    end
    rd_credit = (inflight_cnt + SW'(occupancy)) < SW'(RESP_DEPTH);
  end

  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    mem_addr     = req_addr;
    mem_data_in  = req_wdata;
    case (state_q)
      INIT: begin
        mem_write_en = 1'b1;
        mem_addr     = clear_cnt;
        mem_data_in  = '0;
        if (&clear_cnt) begin
          state_d = RUN;
        end
      end
      RUN: begin
        req_ready    = req_write || rd_credit;
        mem_write_en = req_valid && req_ready && req_write;
        mem_read_en  = req_valid && req_ready && !req_write;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      clear_cnt <= '0;
      init_done <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) begin
        clear_cnt <= clear_cnt + 1'b1;
      end
      if (state_q == INIT && state_d == RUN) begin
        init_done <= 1'b1;
      end
    end
  end

  // Read-valid travels alongside the bank's fixed latency so the capture lines up with mem_data_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe <= {rd_pipe[RD_LATENCY-2:0], mem_read_en};
    end
  end

  assign resp_valid = !fifo_empty;
  assign resp_pop   = resp_valid && resp_ready;

  resp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pipe[RD_LATENCY-1]),
    .push_data (mem_data_out),
    .pop       (resp_pop),
    .pop_data  (resp_rdata),
    .empty     (fifo_empty),
    .count     (occupancy)
  );

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, memory word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, memory address width (2**ADDR_WIDTH words).
REQ-003 SHALL have parameter RESP_DEPTH, default 4, read-response buffer entries (power of two, at least 2).
REQ-004 SHALL have port clk, input, 1, clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port req_valid, input, 1, host request present.
REQ-007 SHALL have port req_ready, output, 1, request accepted this cycle when high together with req_valid.
REQ-008 SHALL have port req_write, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have ports req_addr (input, ADDR_WIDTH) and req_wdata (input, DATA_WIDTH), request address and write data.
REQ-010 SHALL have ports resp_valid (output, 1), resp_ready (input, 1) and resp_rdata (output, DATA_WIDTH), read-response handshake and data.
REQ-011 SHALL have ports mem_write_en, mem_read_en (output, 1 each), mem_addr (output, ADDR_WIDTH) and mem_data_in (output, DATA_WIDTH), driving the downstream memory bank.
REQ-012 SHALL have port mem_data_out, input, DATA_WIDTH, memory bank read data.
REQ-013 SHALL have port init_done, output, 1, high once memory clear is complete.

Function
REQ-014 SHALL implement FSM states INIT and RUN; reset enters INIT.
REQ-015 INIT: each cycle, mem_write_en=1, mem_data_in=0, mem_addr = clear counter; the counter starts at 0 and increments by 1 per cycle.
REQ-016 INIT: after writing address 2**ADDR_WIDTH-1, the FSM moves to RUN on the next edge and init_done goes high and stays high until reset.
REQ-017 In INIT, req_ready SHALL be 0 and mem_read_en SHALL be 0.
REQ-018 RUN: mem_write_en, mem_read_en, mem_addr and mem_data_in SHALL be combinational from the accepted request (req_valid and req_ready), with zero added latency; otherwise both enables are 0.
REQ-019 Memory read latency is fixed at 2 cycles: data for a read issued in cycle N SHALL be captured from mem_data_out at the end of cycle N+2 via a 2-stage valid shift register.
REQ-020 Accepting a read SHALL require (reads in flight + buffer occupancy) < RESP_DEPTH; writes are never blocked by this credit check.
REQ-021 req_ready = RUN and (req_write or credit available).
REQ-022 Responses SHALL be returned in issue order; a read issued before a write to the same address returns the old data, and a read issued after it returns the new data.
REQ-023 The response buffer is a FIFO; resp_valid = not empty, resp_rdata = head entry, and the entry is popped on resp_valid and resp_ready.
REQ-024 A simultaneous push and pop SHALL keep occupancy unchanged; a pop on an empty buffer SHALL be impossible (resp_valid=0).
REQ-025 FIFO pointers SHALL wrap modulo RESP_DEPTH; occupancy counter width is $clog2(RESP_DEPTH)+1.
REQ-026 With resp_ready held high, sustained back-to-back reads SHALL run at 1 per cycle.

Reset
REQ-027 On rst, the following SHALL clear: state=INIT, clear counter=0, init_done=0, in-flight shift register=0, FIFO pointers and occupancy=0; outputs resp_valid=0 and req_ready=0.
REQ-028 rst asserted mid-INIT or mid-RUN SHALL discard all in-flight reads and buffered responses; clearing restarts at address 0.
REQ-029 FIFO data storage SHALL NOT be reset.

Structure
REQ-030 Package mem_pkg SHALL hold DATA_WIDTH/ADDR_WIDTH defaults, the RD_LATENCY=2 constant and the state enum type {INIT, RUN}.
REQ-031 The response buffer SHALL be a sub-module named resp_fifo, parameterised by width and depth.

Verification
REQ-032 Reset release with the memory bank attached -> 64 consecutive write cycles of zeros at addr 0..63; init_done rises on cycle 65; req_ready=0 until then.
REQ-033 Write 0xA5 to addr 5, then read addr 5 on the next cycle -> resp_valid rises exactly 3 cycles after the read is accepted, with resp_rdata=0xA5.
REQ-034 Read addr 7 (value 0x00) followed immediately by write 0x3C to addr 7 -> response 0x00; a subsequent read of addr 7 -> 0x3C.
REQ-035 resp_ready=0, issue 6 reads -> exactly 4 accepted and req_ready low for further reads; writes are still accepted; after 4 pops the remaining 2 reads are accepted.
REQ-036 resp_ready=1, 16 back-to-back reads of addr 0..15 -> 16 in-order responses on consecutive cycles, with no req_ready deassertion.
REQ-037 Assert rst with 2 reads in flight and 2 responses buffered -> resp_valid=0 the cycle after; no stale response appears; INIT restarts at addr 0.
